// File: rtl/fetch_pc_unit.sv
// Fetch program-counter unit: issues sequential fetch addresses, tracks in-flight
// requests in an in-order FIFO and tags them with an epoch so responses fetched
// before a redirect are discarded.
module fetch_pc_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned C_EXT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [XLEN-1:0]          rst_addr,
    input  logic                     redir_vld,
    input  logic [XLEN-1:0]          redir_addr,
    input  logic                     stall,
    output logic                     req_vld,
    output logic [XLEN-1:0]          req_addr,
    input  logic                     req_rdy,
    input  logic                     rsp_vld,
    output logic                     out_vld,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = XLEN - 2;

    // A PC is misaligned if it cannot start a legal instruction.
    function automatic logic misaligned(input logic [XLEN-1:0] a);
        if (C_EXT != 0) begin
            return a[0];
        end
        return |a[1:0];
    endfunction

    logic [XLEN-1:0] pc;
    logic            epoch;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] fifo_pc [DEPTH];
    logic            fifo_ep [DEPTH];

    logic            xfer;
    logic            pop;
    logic            hit;
    logic [XLEN-1:0] pc_next;

    always_comb begin
        req_vld  = !stall && !redir_vld && !err && (inflight < CW'(DEPTH));
        req_addr = pc;
        xfer     = req_vld && req_rdy;
        pop      = rsp_vld && (inflight != '0);
        hit      = pop && (fifo_ep[rd_ptr] == epoch);
        pc_next  = {pc[XLEN-1:2] + WW'(1), 2'b00};
    end

    // Control state: PC, epoch, error flag, FIFO pointers and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= rst_addr;
            epoch    <= 1'b0;
            err      <= misaligned(rst_addr);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            out_vld  <= 1'b0;
            out_pc   <= '0;
        end else begin
            if (redir_vld) begin
                pc    <= redir_addr;
                epoch <= ~epoch;
                err   <= misaligned(redir_addr);
            end else if (xfer) begin
                pc <= pc_next;
            end

            if (xfer) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({xfer, pop})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            // Epoch is compared before any same-cycle redirect toggles it.
            out_vld <= hit;
            if (hit) begin
                out_pc <= fifo_pc[rd_ptr];
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && xfer) begin
            fifo_pc[wr_ptr] <= pc;
            fifo_ep[wr_ptr] <= epoch;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expected output PCs go into a scoreboard
// queue, a negedge monitor pops and compares them whenever out_vld is seen.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rst_addr;
    logic        redir_vld;
    logic [31:0] redir_addr;
    logic        stall;
    logic        req_vld;
    logic [31:0] req_addr;
    logic        req_rdy;
    logic        rsp_vld;
    logic        out_vld;
    logic [31:0] out_pc;
    logic [2:0]  inflight;
    logic        err;

    logic        z_rst_n;
    logic [31:0] z_rst_addr;
    logic        z_redir_vld;
    logic [31:0] z_redir_addr;
    logic        z_req_vld;
    logic [31:0] z_req_addr;
    logic        z_out_vld;
    logic [31:0] z_out_pc;
    logic [2:0]  z_inflight;
    logic        z_err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fetch_pc_unit #(.XLEN(32), .DEPTH(4), .C_EXT(1)) dut (
        .clk(clk), .rst_n(rst_n), .rst_addr(rst_addr),
        .redir_vld(redir_vld), .redir_addr(redir_addr), .stall(stall),
        .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .out_vld(out_vld), .out_pc(out_pc),
        .inflight(inflight), .err(err)
    );

    fetch_pc_unit #(.XLEN(32), .DEPTH(4), .C_EXT(0)) dut0 (
        .clk(clk), .rst_n(z_rst_n), .rst_addr(z_rst_addr),
        .redir_vld(z_redir_vld), .redir_addr(z_redir_addr), .stall(1'b0),
        .req_vld(z_req_vld), .req_addr(z_req_addr), .req_rdy(1'b0),
        .rsp_vld(1'b0), .out_vld(z_out_vld), .out_pc(z_out_pc),
        .inflight(z_inflight), .err(z_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs on the falling edge, then settle.
    task automatic step(input logic rv, input logic [31:0] ra, input logic st,
                        input logic rd, input logic rs);
        @(negedge clk);
        redir_vld  = rv;
        redir_addr = ra;
        stall      = st;
        req_rdy    = rd;
        rsp_vld    = rs;
        #1;
    endtask

    always @(negedge clk) begin
        if (out_vld === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_vld actual_pc=%0h required=no_output at %0t",
                         out_pc, $time);
            end else begin
                chk("out_pc", {32'h0, out_pc}, {32'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst_addr = 32'h1000;
        redir_vld = 1'b0; redir_addr = '0; stall = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0;
        z_rst_n = 1'b0; z_rst_addr = 32'h102; z_redir_vld = 1'b0; z_redir_addr = '0;

        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_err", err, 0);
        chk("rst_req_addr", req_addr, 32'h1000);
        chk("rst_err_c0_misaligned", z_err, 1);
        rst_n = 1'b1;

        // Sequential fetch until the FIFO is full
        step(0, 0, 0, 1, 0);
        chk("seq0_vld", req_vld, 1);
        chk("seq0_addr", req_addr, 32'h1000);
        step(0, 0, 0, 1, 0);
        chk("seq1_addr", req_addr, 32'h1004);
        step(0, 0, 0, 1, 0);
        chk("seq2_addr", req_addr, 32'h1008);
        step(0, 0, 0, 1, 0);
        chk("seq_inflight3", inflight, 3);
        chk("seq3_addr", req_addr, 32'h100c);
        step(0, 0, 0, 1, 1);
        sb.push_back(32'h1000);
        chk("full_vld", req_vld, 0);
        chk("full_inflight", inflight, 4);
        step(0, 0, 0, 0, 1);
        sb.push_back(32'h1004);
        chk("after_pop_vld", req_vld, 1);
        chk("after_pop_inflight", inflight, 3);
        chk("after_pop_addr", req_addr, 32'h1010);
        step(0, 0, 0, 0, 1);
        sb.push_back(32'h1008);
        step(0, 0, 0, 0, 1);
        sb.push_back(32'h100c);
        step(0, 0, 0, 0, 0);
        chk("drain_inflight", inflight, 0);

        // Simultaneous push and pop
        step(0, 0, 0, 1, 0);
        chk("pp_addr0", req_addr, 32'h1010);
        step(0, 0, 0, 1, 1);
        sb.push_back(32'h1010);
        chk("pp_addr1", req_addr, 32'h1014);
        step(0, 0, 0, 0, 1);
        sb.push_back(32'h1014);
        chk("pp_inflight", inflight, 1);
        step(0, 0, 0, 0, 0);
        chk("pp_drain", inflight, 0);

        // Redirect drops stale responses
        step(1, 32'h1000, 0, 1, 0);
        chk("redir_blocks_req", req_vld, 0);
        step(0, 0, 0, 1, 0);
        chk("stale0_addr", req_addr, 32'h1000);
        step(0, 0, 0, 1, 0);
        chk("stale1_addr", req_addr, 32'h1004);
        step(1, 32'h2002, 0, 1, 0);
        chk("stale_inflight", inflight, 2);
        step(0, 0, 0, 0, 1);
        chk("c_ext_half_aligned_err", err, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("stale_dropped_inflight", inflight, 0);
        step(0, 0, 0, 1, 0);
        chk("redir_addr0", req_addr, 32'h2002);
        step(0, 0, 0, 1, 0);
        chk("redir_addr1", req_addr, 32'h2004);
        step(0, 0, 0, 0, 1);
        sb.push_back(32'h2002);
        step(0, 0, 0, 0, 1);
        sb.push_back(32'h2004);

        // Redirect in the same cycle as a response uses the pre-toggle epoch
        step(0, 0, 0, 1, 0);
        chk("same_cyc_addr", req_addr, 32'h2008);
        step(1, 32'h4000, 0, 0, 1);
        sb.push_back(32'h2008);

        // Misaligned redirect sets err and blocks requests
        step(1, 32'h4001, 0, 1, 0);
        chk("pre_mis_inflight", inflight, 0);
        chk("pre_mis_addr", req_addr, 32'h4000);
        step(0, 0, 0, 1, 0);
        chk("mis_err", err, 1);
        chk("mis_blocks", req_vld, 0);
        chk("mis_inflight", inflight, 0);

        // Wrap at the top of the address space
        step(1, 32'hfffffffc, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("wrap_err_clear", err, 0);
        chk("wrap_vld", req_vld, 1);
        chk("wrap_addr_top", req_addr, 32'hfffffffc);
        step(0, 0, 0, 0, 1);
        sb.push_back(32'hfffffffc);
        chk("wrap_addr_zero", req_addr, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("empty_rsp_inflight", inflight, 0);
        step(0, 0, 0, 0, 0);
        chk("empty_rsp_inflight2", inflight, 0);
        chk("empty_rsp_out_vld", out_vld, 0);
        chk("empty_rsp_out_pc", out_pc, 32'hfffffffc);
        chk("empty_rsp_addr", req_addr, 32'h0);

        // Stall blocks transfers; a response during stall still completes
        step(0, 0, 0, 1, 0);
        chk("stall_pre_addr", req_addr, 32'h0);
        step(0, 0, 1, 1, 0);
        chk("stall_vld0", req_vld, 0);
        step(0, 0, 1, 1, 1);
        sb.push_back(32'h0);
        chk("stall_addr1", req_addr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0);
            chk("stall_vld", req_vld, 0);
            chk("stall_addr", req_addr, 32'h4);
        end
        step(0, 0, 0, 0, 0);
        chk("stall_inflight", inflight, 0);
        chk("stall_end_addr", req_addr, 32'h4);

        // Reset mid-operation discards in-flight entries
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("mid_inflight", inflight, 2);
        rst_n = 1'b0;
        rst_addr = 32'h1001;
        step(0, 0, 0, 0, 0);
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_err", err, 1);
        chk("mid_rst_addr", req_addr, 32'h1001);
        chk("mid_rst_vld", req_vld, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("post_rst_inflight", inflight, 0);
        step(0, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        // C_EXT=0 instance: 2-byte aligned target is an error
        z_rst_addr = 32'h100;
        @(negedge clk);
        #1;
        z_rst_n = 1'b1;
        chk("c0_rst_err_clear", z_err, 0);
        @(negedge clk);
        z_redir_vld = 1'b1;
        z_redir_addr = 32'h3002;
        @(negedge clk);
        z_redir_vld = 1'b0;
        #1;
        chk("c0_mis_err", z_err, 1);
        chk("c0_mis_vld", z_req_vld, 0);
        @(negedge clk);
        z_redir_vld = 1'b1;
        z_redir_addr = 32'h3000;
        @(negedge clk);
        z_redir_vld = 1'b0;
        #1;
        chk("c0_ok_err", z_err, 0);
        chk("c0_ok_vld", z_req_vld, 1);
        chk("c0_ok_addr", z_req_addr, 32'h3000);
        chk("c0_no_out", z_out_vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter XLEN, default 32: address width in bits, minimum 16.
REQ-002 Parameter DEPTH, default 4: maximum in-flight fetch requests; power of 2, minimum 2.
REQ-003 Parameter C_EXT, default 1: 1 = 2-byte PC alignment allowed; 0 = 4-byte alignment required.
REQ-004 clk  in  1: clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset; synchronous, active-low.
REQ-006 rst_addr  in  XLEN: PC value loaded during reset.
REQ-007 redir_vld  in  1: redirect (jump/branch/trap) request this cycle.
REQ-008 redir_addr  in  XLEN: redirect target.
REQ-009 stall  in  1: suppresses new fetch requests.
REQ-010 req_vld  out  1: fetch request valid.
REQ-011 req_addr  out  XLEN: fetch address; equals current PC.
REQ-012 req_rdy  in  1: memory accepts request; transfer when req_vld and req_rdy are both 1.
REQ-013 rsp_vld  in  1: in-order memory response for the oldest in-flight request.
REQ-014 out_vld  out  1: registered; the PC of a non-stale response is valid.
REQ-015 out_pc  out  XLEN: PC associated with out_vld.
REQ-016 inflight  out  $clog2(DEPTH)+1: number of outstanding requests.
REQ-017 err  out  1: misaligned-PC error, sticky until cleared.

Function
REQ-018 req_vld SHALL be !stall & !redir_vld & !err & (inflight < DEPTH), purely combinational from state and inputs.
REQ-019 On transfer, PC SHALL advance to {pc[XLEN-1:2]+1, 2'b00}, wrapping modulo 2^XLEN, and push {pc, epoch} into the in-flight FIFO.
REQ-020 Priority SHALL be: reset > redirect > transfer > hold; with no transfer, PC holds.
REQ-021 On redir_vld with aligned redir_addr, PC SHALL load redir_addr, epoch SHALL toggle, and err SHALL clear; the FIFO SHALL NOT be flushed.
REQ-022 Alignment: redir_addr SHALL be misaligned when C_EXT=1 and bit0=1, or when C_EXT=0 and bits[1:0]!=0.
REQ-023 On a misaligned redirect, PC SHALL load redir_addr, epoch SHALL toggle, and err SHALL set the next cycle; no requests SHALL be issued while err=1.
REQ-024 rsp_vld with a non-empty FIFO SHALL pop the head; if the head epoch equals the current epoch (sampled in the same cycle, before any toggle), out_vld=1 and out_pc=head PC on the next cycle; otherwise the entry is dropped and out_vld=0.
REQ-025 rsp_vld with an empty FIFO SHALL be ignored: no pop, no out_vld, inflight unchanged.
REQ-026 Simultaneous push and pop SHALL leave inflight unchanged, and both operations SHALL take effect.
REQ-027 A redirect in the same cycle as rsp_vld SHALL still pop; the popped entry is compared against the pre-toggle epoch.
REQ-028 out_vld SHALL be a single-cycle pulse per accepted response; there is no back-pressure on the output.
REQ-029 inflight SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-030 While rst_n=0 at a clock edge: pc=rst_addr, epoch=0, FIFO empty, inflight=0, out_vld=0, out_pc=0.
REQ-031 During reset, err SHALL be set iff rst_addr is misaligned per REQ-022.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries; later rsp_vld pulses SHALL be ignored per REQ-025.

Verification
REQ-033 Reset with rst_addr=0x1000 and req_rdy=1 for 3 cycles -> req_addr sequence 0x1000, 0x1004, 0x1008; inflight=3.
REQ-034 DEPTH=4, req_rdy=1, no responses -> 4 transfers, then req_vld=0 with inflight=4; a single rsp_vld -> out_vld=1 with out_pc=first PC on the next cycle, and req_vld reasserts.
REQ-035 2 requests in flight (0x1000, 0x1004), redirect to 0x2002 (C_EXT=1), then 2 rsp_vld -> both dropped (out_vld=0); next requests 0x2002, 0x2004.
REQ-036 C_EXT=0, redirect to 0x3002 -> err=1 and req_vld=0; then redirect to 0x3000 -> err=0 and req_addr=0x3000.
REQ-037 PC=0xFFFFFFFC, transfer -> PC wraps to 0x00000000; rsp_vld while empty -> no change in any output.
REQ-038 stall=1 with req_rdy=1 for 5 cycles -> no transfers and PC constant; a response arriving during the stall still produces out_vld.
